// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - counter width and window tap layout helpers shared by conv_window_gen
package conv_pkg;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Tap (0,0) occupies the most significant pixel slot of the window word.
    function automatic int tap_lsb(input int i, input int j, input int k, input int pix_w);
        return (k * k - 1 - (i * k + j)) * pix_w;
    endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// rtl/line_buffer_ram.sv - one image row of pixels, read-then-write at the same column per push
module line_buffer_ram
    import conv_pkg::*;
#(
    parameter int DEPTH = 224,
    parameter int WIDTH = 16,
    parameter int AW    = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             i_push,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Combinational read returns the pixel one row above before it is overwritten.
    assign o_data = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[i_addr] <= i_data;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - KxK sliding-window generator with stride and valid/ready flow control
// Optional: LAST_FLAG_EN adds out_last marking the final window of each frame.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int IMG_W  = 224,
    parameter int IMG_H  = 224,
    parameter int DATA_W = 16,
    parameter int CH     = 1,
    parameter int K      = 3,
    parameter int S      = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CH*DATA_W-1:0]      in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [K*K*CH*DATA_W-1:0]  out_data,
    output logic                      out_valid,
    input  logic                      out_ready
`ifdef LAST_FLAG_EN
    ,
    output logic                      out_last
`endif
);

    localparam int PW = CH * DATA_W;
    localparam int CW = cnt_w(IMG_W);
    localparam int RW = cnt_w(IMG_H);
    localparam int SW = cnt_w(S);

    logic [CW-1:0]      r_col;
    logic [RW-1:0]      r_row;
    logic [SW-1:0]      r_col_ph;
    logic [SW-1:0]      r_row_ph;
    logic [PW-1:0]      r_win [K][K];
    logic               r_out_valid;
    logic [K*K*PW-1:0]  r_out_data;

    logic [PW-1:0]      w_col_vec [K];
    logic [PW-1:0]      w_win_nxt [K][K];
    logic [K*K*PW-1:0]  w_win_flat;
    logic               w_accept;
    logic               w_emit;
    logic               w_col_end;
    logic               w_row_end;

    assign in_ready  = !r_out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_col_end = (r_col == CW'(IMG_W - 1));
    assign w_row_end = (r_row == RW'(IMG_H - 1));
    assign w_emit    = w_accept && (r_row >= RW'(K - 1)) && (r_col >= CW'(K - 1))
                       && (r_row_ph == '0) && (r_col_ph == '0);

    // Row K-1 of the column is the live pixel; each line buffer steps one row further up.
    assign w_col_vec[K-1] = in_data;
    for (genvar g = 0; g < K - 1; g++) begin : g_lb
        line_buffer_ram #(.DEPTH(IMG_W), .WIDTH(PW), .AW(CW)) u_lb (
            .clk    (clk),
            .i_push (w_accept),
            .i_addr (r_col),
            .i_data (w_col_vec[K-1-g]),
            .o_data (w_col_vec[K-2-g])
        );
    end

    always_comb begin
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K - 1; j++) begin
                w_win_nxt[i][j] = r_win[i][j+1];
            end
            w_win_nxt[i][K-1] = w_col_vec[i];
        end
    end

    always_comb begin
        w_win_flat = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                w_win_flat[tap_lsb(i, j, K, PW) +: PW] = w_win_nxt[i][j];
            end
        end
    end

    function automatic logic [SW-1:0] ph_inc(input logic [SW-1:0] ph);
        return (ph == SW'(S - 1)) ? '0 : ph + 1'b1;
    endfunction

    // Phase counters track (pos-(K-1)) mod S; they stay 0 until the first full window column/row.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col    <= '0;
            r_row    <= '0;
            r_col_ph <= '0;
            r_row_ph <= '0;
        end else if (w_accept) begin
            if (w_col_end) begin
                r_col    <= '0;
                r_col_ph <= '0;
                if (w_row_end) begin
                    r_row    <= '0;
                    r_row_ph <= '0;
                end else begin
                    r_row    <= r_row + 1'b1;
                    r_row_ph <= (r_row >= RW'(K - 1)) ? ph_inc(r_row_ph) : '0;
                end
            end else begin
                r_col    <= r_col + 1'b1;
                r_col_ph <= (r_col >= CW'(K - 1)) ? ph_inc(r_col_ph) : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_win <= w_win_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_emit) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_win_flat;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

`ifdef LAST_FLAG_EN
    localparam int LAST_COL = K - 1 + ((IMG_W - K) / S) * S;
    localparam int LAST_ROW = K - 1 + ((IMG_H - K) / S) * S;

    logic r_out_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_last <= 1'b0;
        end else if (w_emit) begin
            r_out_last <= (r_row == RW'(LAST_ROW)) && (r_col == CW'(LAST_COL));
        end else if (out_ready) begin
            r_out_last <= 1'b0;
        end
    end

    assign out_last = r_out_last;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// tb/tb_conv_window_gen.sv - self-checking bench for conv_window_gen (three configurations)
module tb_conv_window_gen;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // dut0: 5x4, K=3, S=1, CH=1
    logic [15:0]  d0_in;
    logic         d0_iv, d0_ir, d0_ov, d0_or, d0_last;
    logic [143:0] d0_out;
    // dut1: 6x6, K=3, S=2, CH=1
    logic [15:0]  d1_in;
    logic         d1_iv, d1_ir, d1_ov, d1_or, d1_last;
    logic [143:0] d1_out;
    // dut2: 7x5, K=3, S=2, CH=3
    logic [47:0]  d2_in;
    logic         d2_iv, d2_ir, d2_ov, d2_or, d2_last;
    logic [431:0] d2_out;

    conv_window_gen #(.IMG_W(5), .IMG_H(4), .DATA_W(16), .CH(1), .K(3), .S(1)) u_dut0 (
        .clk(clk), .rst(rst), .in_data(d0_in), .in_valid(d0_iv), .in_ready(d0_ir),
        .out_data(d0_out), .out_valid(d0_ov), .out_ready(d0_or)
`ifdef LAST_FLAG_EN
        , .out_last(d0_last)
`endif
    );

    conv_window_gen #(.IMG_W(6), .IMG_H(6), .DATA_W(16), .CH(1), .K(3), .S(2)) u_dut1 (
        .clk(clk), .rst(rst), .in_data(d1_in), .in_valid(d1_iv), .in_ready(d1_ir),
        .out_data(d1_out), .out_valid(d1_ov), .out_ready(d1_or)
`ifdef LAST_FLAG_EN
        , .out_last(d1_last)
`endif
    );

    conv_window_gen #(.IMG_W(7), .IMG_H(5), .DATA_W(16), .CH(3), .K(3), .S(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_data(d2_in), .in_valid(d2_iv), .in_ready(d2_ir),
        .out_data(d2_out), .out_valid(d2_ov), .out_ready(d2_or)
`ifdef LAST_FLAG_EN
        , .out_last(d2_last)
`endif
    );

`ifndef LAST_FLAG_EN
    assign d0_last = 1'b0;
    assign d1_last = 1'b0;
    assign d2_last = 1'b0;
`endif

    logic [431:0] g0_d[$], g1_d[$], g2_d[$];
    bit           g0_l[$], g1_l[$], g2_l[$];
    logic [431:0] exp_d[$];
    bit           exp_l[$];
    logic [47:0]  px_q[$];
    int           first_v0 = -1;
    int           acc_cyc  = -2;

    always @(negedge clk) begin
        if (!rst && d0_ov && d0_or) begin g0_d.push_back(432'(d0_out)); g0_l.push_back(d0_last); end
        if (!rst && d1_ov && d1_or) begin g1_d.push_back(432'(d1_out)); g1_l.push_back(d1_last); end
        if (!rst && d2_ov && d2_or) begin g2_d.push_back(d2_out);       g2_l.push_back(d2_last); end
        if (!rst && d0_ov && first_v0 < 0) first_v0 = cyc;
    end

    task automatic chk(input string nm, input logic [431:0] act, input logic [431:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Window whose top-left pixel has raster value tl, when pixel value == raster index.
    function automatic logic [431:0] raster_win(input int tl, input int w, input int k, input int pw);
        logic [431:0] acc;
        logic [431:0] p;
        acc = '0;
        for (int i = 0; i < k; i++) begin
            for (int j = 0; j < k; j++) begin
                p   = 432'(tl + i * w + j);
                acc = acc | (p << ((k * k - 1 - (i * k + j)) * pw));
            end
        end
        return acc;
    endfunction

    // Golden windows from the recorded accepted-pixel stream, one frame at a time.
    task automatic build_exp(input int w, input int h, input int k, input int s, input int pw, input int nfr);
        logic [431:0] acc;
        logic [431:0] p;
        int lr, lc;
        exp_d.delete();
        exp_l.delete();
        lr = k - 1 + ((h - k) / s) * s;
        lc = k - 1 + ((w - k) / s) * s;
        for (int f = 0; f < nfr; f++) begin
            for (int r = k - 1; r < h; r += s) begin
                for (int c = k - 1; c < w; c += s) begin
                    acc = '0;
                    for (int i = 0; i < k; i++) begin
                        for (int j = 0; j < k; j++) begin
                            p   = 432'(px_q[f * w * h + (r - k + 1 + i) * w + (c - k + 1 + j)]);
                            acc = acc | (p << ((k * k - 1 - (i * k + j)) * pw));
                        end
                    end
                    exp_d.push_back(acc);
                    exp_l.push_back(r == lr && c == lc);
                end
            end
        end
    endtask

    task automatic compare_win(input string tag, input logic [431:0] got[$], input bit gl[$]);
        chk({tag, " count"}, 432'(got.size()), 432'(exp_d.size()));
        for (int n = 0; n < got.size() && n < exp_d.size(); n++) begin
            chk($sformatf("%s win%0d", tag, n), got[n], exp_d[n]);
`ifdef LAST_FLAG_EN
            chk($sformatf("%s last%0d", tag, n), 432'(gl[n]), 432'(exp_l[n]));
`endif
        end
    endtask

    // Stream npix raster-valued pixels into dut0; hold out_ready low for `stall` cycles on the first window.
    task automatic drive0(input int npix, input int stall);
        int sent = 0;
        int guard = 0;
        int left = stall;
        while (sent < npix && guard < 2000) begin
            guard++;
            d0_or = !(left > 0 && d0_ov);
            d0_iv = 1'b1;
            d0_in = 16'(sent);
            @(negedge clk);
            if (!d0_or) begin
                chk("stall in_ready", 432'(d0_ir), 432'(0));
                chk("stall out_data", 432'(d0_out), raster_win(0, 5, 3, 16));
                left--;
            end
            if (d0_ir) begin
                px_q.push_back(48'(sent));
                if (sent == 12) acc_cyc = cyc + 1;
                sent++;
            end
            @(posedge clk); #1;
        end
        if (sent < npix) chk("drive0 timeout", 432'(sent), 432'(npix));
        d0_iv = 1'b0;
        d0_or = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic push0(input int npix, input logic rdy);
        int sent = 0;
        int guard = 0;
        while (sent < npix && guard < 500) begin
            guard++;
            d0_or = rdy;
            d0_iv = 1'b1;
            d0_in = 16'(sent);
            @(negedge clk);
            if (d0_ir) sent++;
            @(posedge clk); #1;
        end
        if (sent < npix) chk("push0 timeout", 432'(sent), 432'(npix));
        d0_iv = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    typedef struct {
        int nfr;
        int stall;
        int exp_cnt;
        int chk_idx;
        int chk_tl;
    } scen_t;

    scen_t tbl[3];
    int    tls1[4];

    initial begin
        tbl[0] = '{1, 0, 6, 0, 0};
        tbl[1] = '{1, 5, 6, 0, 0};
        tbl[2] = '{2, 0, 12, 6, 20};
        tls1   = '{0, 2, 12, 14};

        rst = 1'b1;
        d0_iv = 1'b0; d0_or = 1'b1; d0_in = '0;
        d1_iv = 1'b0; d1_or = 1'b1; d1_in = '0;
        d2_iv = 1'b0; d2_or = 1'b1; d2_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset d0 out_valid", 432'(d0_ov), 432'(0));
        chk("reset d0 out_data", 432'(d0_out), 432'(0));
        chk("reset d0 in_ready", 432'(d0_ir), 432'(1));
        chk("reset d1 out_valid", 432'(d1_ov), 432'(0));
        chk("reset d2 out_valid", 432'(d2_ov), 432'(0));
        chk("reset d2 out_data", d2_out, 432'(0));
        chk("reset d0 out_last", 432'(d0_last), 432'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        for (int t = 0; t < 3; t++) begin
            px_q.delete(); g0_d.delete(); g0_l.delete();
            first_v0 = -1;
            acc_cyc  = -2;
            drive0(tbl[t].nfr * 20, tbl[t].stall);
            build_exp(5, 4, 3, 1, 16, tbl[t].nfr);
            compare_win($sformatf("scen%0d", t), g0_d, g0_l);
            chk($sformatf("scen%0d table count", t), 432'(g0_d.size()), 432'(tbl[t].exp_cnt));
            if (g0_d.size() > tbl[t].chk_idx)
                chk($sformatf("scen%0d key window", t), g0_d[tbl[t].chk_idx], raster_win(tbl[t].chk_tl, 5, 3, 16));
            chk($sformatf("scen%0d first latency", t), 432'(first_v0), 432'(acc_cyc));
        end

        // Reset mid-frame after pixel 9, then with a window pending, then a clean frame.
        push0(10, 1'b1);
        pulse_rst();
        @(negedge clk);
        chk("rst after px9 out_valid", 432'(d0_ov), 432'(0));
        @(posedge clk); #1;
        push0(13, 1'b0);
        @(negedge clk);
        chk("pending window valid", 432'(d0_ov), 432'(1));
        @(posedge clk); #1;
        pulse_rst();
        @(negedge clk);
        chk("rst drops pending valid", 432'(d0_ov), 432'(0));
        chk("rst clears out_data", 432'(d0_out), 432'(0));
        @(posedge clk); #1;
        d0_or = 1'b1;
        px_q.delete(); g0_d.delete(); g0_l.delete();
        drive0(20, 0);
        build_exp(5, 4, 3, 1, 16, 1);
        compare_win("after rst", g0_d, g0_l);

        // Stride 2 on 6x6.
        px_q.delete();
        begin
            int sent = 0;
            int guard = 0;
            while (sent < 36 && guard < 500) begin
                guard++;
                d1_iv = 1'b1;
                d1_in = 16'(sent);
                @(negedge clk);
                if (d1_ir) begin px_q.push_back(48'(sent)); sent++; end
                @(posedge clk); #1;
            end
            if (sent < 36) chk("drive1 timeout", 432'(sent), 432'(36));
            d1_iv = 1'b0;
            repeat (4) @(posedge clk);
            #1;
        end
        build_exp(6, 6, 3, 2, 16, 1);
        compare_win("stride2", g1_d, g1_l);
        for (int n = 0; n < 4 && n < g1_d.size(); n++)
            chk($sformatf("stride2 tl%0d", tls1[n]), g1_d[n], raster_win(tls1[n], 6, 3, 16));

        // Random data and random handshakes, CH=3, two frames.
        px_q.delete();
        begin
            int sent = 0;
            int guard = 0;
            logic [63:0] rnd;
            while (sent < 70 && guard < 5000) begin
                guard++;
                rnd   = {$urandom, $urandom};
                d2_in = rnd[47:0];
                d2_iv = ($urandom_range(0, 3) != 0);
                d2_or = ($urandom_range(0, 2) != 0);
                @(negedge clk);
                if (d2_iv && d2_ir) begin px_q.push_back(d2_in); sent++; end
                @(posedge clk); #1;
            end
            if (sent < 70) chk("drive2 timeout", 432'(sent), 432'(70));
            d2_iv = 1'b0;
            d2_or = 1'b1;
            repeat (4) @(posedge clk);
            #1;
        end
        build_exp(7, 5, 3, 2, 48, 2);
        compare_win("random ch3", g2_d, g2_l);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
